// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between stopwatch_ctrl and its button/tick sources and counter/display sinks.
// The pb_lap pulse exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       pb_start;
    logic       pb_clear;
`ifdef STOPWATCH_LAP_EN
    logic       pb_lap;
`endif
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic       cnt_load;
    logic       cnt_dec;
    logic [3:0] disp_tens;
    logic [3:0] disp_ones;
    logic       led_run;
    logic       led_done;
    logic [1:0] state;

    modport slave (
        input  tick, pb_start, pb_clear,
`ifdef STOPWATCH_LAP_EN
        input  pb_lap,
`endif
        input  cnt_tens, cnt_ones,
        output cnt_load, cnt_dec, disp_tens, disp_ones, led_run, led_done, state
    );

    modport master (
        output tick, pb_start, pb_clear,
`ifdef STOPWATCH_LAP_EN
        output pb_lap,
`endif
        output cnt_tens, cnt_ones,
        input  cnt_load, cnt_dec, disp_tens, disp_ones, led_run, led_done, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Sequencer for the 2-digit BCD down-counting stopwatch: buttons and 1 Hz tick to counter strobes,
// LEDs and display digits. Define STOPWATCH_LAP_EN to add the pb_lap display-hold feature.
module stopwatch_ctrl #(
    parameter logic [3:0] INIT_TENS   = 4'd2,
    parameter logic [3:0] INIT_ONES   = 4'd5,
    parameter int         BLINK_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    state_t        state_q, state_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_dec_q, cnt_dec_d;
    logic [3:0]    disp_tens_q, disp_tens_d;
    logic [3:0]    disp_ones_q, disp_ones_d;
    logic          led_run_q, led_run_d;
    logic          led_done_q, led_done_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          cnt_zero;
`ifdef STOPWATCH_LAP_EN
    logic          hold_q, hold_d;
`endif

    // Non-BCD digits are simply nonzero here, so they keep counting rather than stalling.
    assign cnt_zero = ({bus.cnt_tens, bus.cnt_ones} == 8'h00);

    always_comb begin
        state_d    = state_q;
        cnt_load_d = 1'b0;
        cnt_dec_d  = 1'b0;
        led_done_d = led_done_q;
        blink_d    = blink_q;
`ifdef STOPWATCH_LAP_EN
        hold_d     = hold_q;
`endif
        if (bus.pb_clear) begin
            state_d    = ST_IDLE;
            cnt_load_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.pb_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pb_start) begin
                        state_d = ST_PAUSE;
                    end else begin
                        if (bus.tick) begin
                            if (cnt_zero) state_d   = ST_DONE;
                            else          cnt_dec_d = 1'b1;
                        end
`ifdef STOPWATCH_LAP_EN
                        if (bus.pb_lap) hold_d = ~hold_q;
`endif
                    end
                end
                ST_PAUSE: begin
                    if (bus.pb_start) state_d = ST_RUN;
                end
                ST_DONE: begin
                    if (bus.tick) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_d    = '0;
                            led_done_d = ~led_done_q;
                        end else begin
                            blink_d = blink_q + BW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Blink phase starts lit on DONE entry and is wiped whenever DONE is not the next state.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            led_done_d = 1'b1;
            blink_d    = '0;
        end
        if (state_d != ST_DONE) begin
            led_done_d = 1'b0;
            blink_d    = '0;
        end
        led_run_d = (state_d == ST_RUN);

`ifdef STOPWATCH_LAP_EN
        if (state_d == ST_IDLE || state_d == ST_DONE) hold_d = 1'b0;
        if (hold_d && hold_q) begin
            disp_tens_d = disp_tens_q;
            disp_ones_d = disp_ones_q;
        end else begin
            disp_tens_d = bus.cnt_tens;
            disp_ones_d = bus.cnt_ones;
        end
`else
        disp_tens_d = bus.cnt_tens;
        disp_ones_d = bus.cnt_ones;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_load_q  <= 1'b1;
            cnt_dec_q   <= 1'b0;
            disp_tens_q <= 4'd0;
            disp_ones_q <= 4'd0;
            led_run_q   <= 1'b0;
            led_done_q  <= 1'b0;
            blink_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_load_q  <= cnt_load_d;
            cnt_dec_q   <= cnt_dec_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            led_run_q   <= led_run_d;
            led_done_q  <= led_done_d;
            blink_q     <= blink_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= 1'b0;
        else     hold_q <= hold_d;
    end
`endif

    assign bus.cnt_load  = cnt_load_q;
    assign bus.cnt_dec   = cnt_dec_q;
    assign bus.disp_tens = disp_tens_q;
    assign bus.disp_ones = disp_ones_q;
    assign bus.led_run   = led_run_q;
    assign bus.led_done  = led_done_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl; counter digits are driven directly as vectors.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.INIT_TENS(4'd2), .INIT_ONES(4'd5), .BLINK_TICKS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of button/tick inputs, then sample 1 time unit after the edge.
    task automatic step(input logic start, input logic clear, input logic tk);
        @(negedge clk);
        bus.pb_start = start;
        bus.pb_clear = clear;
        bus.tick     = tk;
        @(posedge clk);
        #1;
        bus.pb_start = 1'b0;
        bus.pb_clear = 1'b0;
        bus.tick     = 1'b0;
    endtask

    task automatic set_cnt(input logic [7:0] v);
        @(negedge clk);
        bus.cnt_tens = v[7:4];
        bus.cnt_ones = v[3:0];
    endtask

    task automatic test_reset;
        bus.pb_start = 1'b0; bus.pb_clear = 1'b0; bus.tick = 1'b0;
`ifdef STOPWATCH_LAP_EN
        bus.pb_lap = 1'b0;
`endif
        bus.cnt_tens = 4'd2; bus.cnt_ones = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_load !== 1'b1 || bus.cnt_dec !== 1'b0 ||
            bus.led_run !== 1'b0 || bus.led_done !== 1'b0 || {bus.disp_tens, bus.disp_ones} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: state=%b load=%b dec=%b run=%b done=%b disp=%h required 00 1 0 0 0 00",
                     bus.state, bus.cnt_load, bus.cnt_dec, bus.led_run, bus.led_done, {bus.disp_tens, bus.disp_ones});
        end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        n_cmp++;
        if (bus.cnt_load !== 1'b0 || bus.state !== 2'b00 || {bus.disp_tens, bus.disp_ones} !== 8'h25) begin
            n_fail++;
            $display("FAIL reset_release: load=%b state=%b disp=%h required 0 00 25",
                     bus.cnt_load, bus.state, {bus.disp_tens, bus.disp_ones});
        end
        $display("reset: state=%b load=%b", bus.state, bus.cnt_load);
    endtask

    task automatic test_idle_tick;
        step(0, 0, 1);
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick: state=%b dec=%b required 00 0", bus.state, bus.cnt_dec);
        end
        $display("idle tick: state=%b dec=%b", bus.state, bus.cnt_dec);
    endtask

    task automatic test_run;
        logic [7:0] cnt_v [3] = '{8'h25, 8'h24, 8'h23};
        step(1, 0, 0);
        n_cmp++;
        if (bus.state !== 2'b01 || bus.led_run !== 1'b1 || bus.cnt_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start: state=%b run=%b dec=%b required 01 1 0", bus.state, bus.led_run, bus.cnt_dec);
        end
        for (int i = 0; i < 3; i++) begin
            set_cnt(cnt_v[i]);
            step(0, 0, 1);
            n_cmp++;
            if (bus.cnt_dec !== 1'b1 || {bus.disp_tens, bus.disp_ones} !== cnt_v[i]) begin
                n_fail++;
                $display("FAIL run_tick%0d: dec=%b disp=%h required 1 %h", i, bus.cnt_dec,
                         {bus.disp_tens, bus.disp_ones}, cnt_v[i]);
            end
            step(0, 0, 0);
            n_cmp++;
            if (bus.cnt_dec !== 1'b0) begin
                n_fail++;
                $display("FAIL run_dec_width%0d: dec=%b required 0", i, bus.cnt_dec);
            end
            $display("run tick %0d: cnt=%h dec pulse seen", i, cnt_v[i]);
        end
    endtask

    task automatic test_pause;
        set_cnt(8'h22);
        step(1, 0, 1);
        n_cmp++;
        if (bus.state !== 2'b10 || bus.cnt_dec !== 1'b0 || bus.led_run !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: state=%b dec=%b run=%b required 10 0 0", bus.state, bus.cnt_dec, bus.led_run);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1);
            n_cmp++;
            if (bus.state !== 2'b10 || bus.cnt_dec !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_tick%0d: state=%b dec=%b required 10 0", i, bus.state, bus.cnt_dec);
            end
        end
        step(1, 0, 0);
        n_cmp++;
        if (bus.state !== 2'b01 || bus.led_run !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume: state=%b run=%b required 01 1", bus.state, bus.led_run);
        end
        $display("pause/resume: state=%b", bus.state);
    endtask

    task automatic test_non_bcd;
        set_cnt(8'h0A);
        step(0, 0, 1);
        n_cmp++;
        if (bus.state !== 2'b01 || bus.cnt_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL non_bcd: state=%b dec=%b required 01 1", bus.state, bus.cnt_dec);
        end
        $display("non-bcd 0A tick: dec=%b", bus.cnt_dec);
    endtask

    task automatic test_back_to_back;
        set_cnt(8'h10);
        step(0, 0, 1);
        step(0, 0, 1);
        n_cmp++;
        if (bus.cnt_dec !== 1'b1 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL back_to_back: dec=%b state=%b required 1 01", bus.cnt_dec, bus.state);
        end
        $display("back-to-back ticks: dec=%b", bus.cnt_dec);
    endtask

    task automatic test_done;
        set_cnt(8'h00);
        step(0, 0, 1);
        n_cmp++;
        if (bus.state !== 2'b11 || bus.cnt_dec !== 1'b0 || bus.led_done !== 1'b1 || bus.led_run !== 1'b0) begin
            n_fail++;
            $display("FAIL done_enter: state=%b dec=%b done=%b run=%b required 11 0 1 0",
                     bus.state, bus.cnt_dec, bus.led_done, bus.led_run);
        end
        step(0, 0, 0);
        n_cmp++;
        if (bus.led_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: led_done=%b required 1", bus.led_done);
        end
        step(0, 0, 1);
        n_cmp++;
        if (bus.led_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_blink1: led_done=%b required 0", bus.led_done);
        end
        step(0, 0, 1);
        n_cmp++;
        if (bus.led_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_blink2: led_done=%b required 1", bus.led_done);
        end
        step(1, 0, 0);
        n_cmp++;
        if (bus.state !== 2'b11 || bus.led_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_start_ignored: state=%b done=%b required 11 1", bus.state, bus.led_done);
        end
        $display("done: state=%b led_done=%b", bus.state, bus.led_done);
    endtask

    task automatic test_clear;
        step(1, 1, 1);
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_load !== 1'b1 || bus.cnt_dec !== 1'b0 || bus.led_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done: state=%b load=%b dec=%b done=%b required 00 1 0 0",
                     bus.state, bus.cnt_load, bus.cnt_dec, bus.led_done);
        end
        step(0, 0, 0);
        n_cmp++;
        if (bus.cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_done_width: load=%b required 0", bus.cnt_load);
        end
        set_cnt(8'h12);
        step(1, 0, 0);
        step(1, 1, 1);
        n_cmp++;
        if (bus.state !== 2'b00 || bus.cnt_load !== 1'b1 || bus.cnt_dec !== 1'b0 || bus.led_run !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_run: state=%b load=%b dec=%b run=%b required 00 1 0 0",
                     bus.state, bus.cnt_load, bus.cnt_dec, bus.led_run);
        end
        step(0, 0, 0);
        n_cmp++;
        if (bus.cnt_load !== 1'b0 || bus.state !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_run_width: load=%b state=%b required 0 00", bus.cnt_load, bus.state);
        end
        $display("clear: state=%b load=%b", bus.state, bus.cnt_load);
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap;
        set_cnt(8'h18);
        step(1, 0, 0);
        @(negedge clk);
        bus.pb_lap = 1'b1;
        @(posedge clk);
        #1;
        bus.pb_lap = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_cnt(8'h18 - 8'(i));
            step(0, 0, 1);
        end
        step(0, 0, 0);
        n_cmp++;
        if ({bus.disp_tens, bus.disp_ones} !== 8'h18) begin
            n_fail++;
            $display("FAIL lap_hold: disp=%h required 18", {bus.disp_tens, bus.disp_ones});
        end
        @(negedge clk);
        bus.pb_lap = 1'b1;
        @(posedge clk);
        #1;
        bus.pb_lap = 1'b0;
        n_cmp++;
        if ({bus.disp_tens, bus.disp_ones} !== 8'h14) begin
            n_fail++;
            $display("FAIL lap_release: disp=%h required 14", {bus.disp_tens, bus.disp_ones});
        end
        $display("lap: disp=%h", {bus.disp_tens, bus.disp_ones});
    endtask
`endif

    initial begin
        test_reset();
        test_idle_tick();
        test_run();
        test_pause();
        test_non_bcd();
        test_back_to_back();
        test_done();
        test_clear();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
